// File: rtl/serial_tx.sv
// UART transmitter: a valid/ready byte FIFO feeding an 8N1 serialiser, LSB first.
// The line is registered, so it lags the FSM state by one clock.
module serial_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_valid_in,
  output logic       tx_ready_out,
  output logic       data_out,
  output logic       busy_out
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  state_t      r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic [15:0] r_baud_cnt;
  logic        r_data_out;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_baud_done;
  state_t      w_state_nxt;
  logic        w_data_nxt;

  // Handshake: a byte transfers on any rising edge where tx_valid_in and
  // tx_ready_out are both high; valid without ready is simply ignored.
  assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty      = (r_wptr == r_rptr);
  assign w_push       = tx_valid_in && !w_full;
  assign w_baud_done  = (r_baud_cnt == BAUD_LAST);

  assign tx_ready_out = !w_full;
  assign data_out     = r_data_out;
  assign busy_out     = (r_state != S_IDLE) || !w_empty;

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= tx_data_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_data_nxt  = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_data_nxt = 1'b0;
        if (w_baud_done) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_data_nxt = r_shift[0];
        if (w_baud_done && r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        // Last stop cycle chains straight into the next start bit when data waits.
        if (w_baud_done && r_bit_cnt == STOP_LAST) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_data_out <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_data_out <= w_data_nxt;
      if (w_pop) begin
        r_shift <= r_mem[r_rptr[AW-1:0]];
      end else if (r_state == S_DATA && w_baud_done) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end
      if (r_state == S_IDLE || w_state_nxt != r_state) begin
        r_baud_cnt <= '0;
        r_bit_cnt  <= '0;
      end else if (w_baud_done) begin
        r_baud_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end else begin
        r_baud_cnt <= r_baud_cnt + 16'd1;
      end
    end
  end

endmodule
